// File: rtl/key_checker_pkg.sv
// Purpose: shared state encoding and width helpers for the key checker slice.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
// Contents: state_t enum, cnt_w() (width holding 0..n), idx_w() (width addressing 0..n-1).
package key_checker_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    CHECK   = 2'd1,
    DONE    = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  // Width of a counter holding values 0..n. Never narrower than one bit, so
  // a disabled feature (n = 0) still gets a legal vector.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Width of an index addressing 0..n-1, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DEF_SYM_W     = 2;
  localparam int unsigned DEF_KEY_LEN   = 4;
  localparam int unsigned DEF_MAX_FAILS = 3;

endpackage

// File: rtl/key_checker_param_if.sv
// Purpose: bundle of the symbol handshake, key/restart controls and status outputs.
// Latency: n/a (wiring only).
// Backpressure: sym_ready from the checker side throttles sym_valid/sym_in.
// Modports: master = symbol source / controller, slave = key_checker_param.
interface key_checker_param_if #(
  parameter int unsigned SYM_W     = key_checker_pkg::DEF_SYM_W,
  parameter int unsigned KEY_LEN   = key_checker_pkg::DEF_KEY_LEN,
  parameter int unsigned MAX_FAILS = key_checker_pkg::DEF_MAX_FAILS
);
  localparam int unsigned FC_W = key_checker_pkg::cnt_w(MAX_FAILS);
  localparam int unsigned CC_W = key_checker_pkg::cnt_w(KEY_LEN);

  logic                     sym_valid;
  logic [SYM_W-1:0]         sym_in;
  logic                     sym_ready;
  logic [KEY_LEN*SYM_W-1:0] key;
  logic                     restart;
  logic                     success;
  logic                     fail;
  logic                     locked;
  logic [FC_W-1:0]          fail_count;
  logic [CC_W-1:0]          check_cycles;

  modport master (
    output sym_valid, sym_in, key, restart,
    input  sym_ready, success, fail, locked, fail_count, check_cycles
  );

  modport slave (
    input  sym_valid, sym_in, key, restart,
    output sym_ready, success, fail, locked, fail_count, check_cycles
  );

endinterface

// File: rtl/key_checker_param_lockout_timer.sv
// Purpose: load/count-down timer measuring the lockout period.
// Latency: o_expired is high in the CYCLES-th cycle after the i_start edge.
// Backpressure: none; i_start reloads the counter at any time.
// Ports: clk, rst (async active-low), i_start (load pulse), o_expired (one-cycle pulse).
module lockout_timer
  import key_checker_pkg::*;
#(
  parameter int unsigned CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  output logic o_expired
);
  localparam int unsigned CNT_W = cnt_w(CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic             r_active;

  // Loaded with CYCLES on the start edge; the owner sees expired while the
  // count reads 1, so it leaves lockout exactly CYCLES cycles after entering.
  assign o_expired = r_active && (r_cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (i_start) begin
      r_cnt    <= CNT_W'(CYCLES);
      r_active <= 1'b1;
    end else if (r_active) begin
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == CNT_W'(1)) r_active <= 1'b0;
    end
  end

endmodule

// File: rtl/key_checker_param.sv
// Purpose: collect KEY_LEN symbols, compare serially against a snapshotted key, count failures, lock out.
// Latency: verdict at T0+i+1 on first mismatch i (T0+KEY_LEN with KEY_CHECKER_CONSTANT_TIME_EN), T0+KEY_LEN on match.
// Backpressure: sym_ready is high only in COLLECT; symbols offered elsewhere are not taken.
// Ports: clk, rst (async active-low), bus (key_checker_param_if.slave).
// Build option: define KEY_CHECKER_CONSTANT_TIME_EN for a compare whose duration never depends on the data.
module key_checker_param
  import key_checker_pkg::*;
#(
  parameter int unsigned SYM_W          = 2,
  parameter int unsigned KEY_LEN        = 4,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst,
  key_checker_param_if.slave bus
);
  localparam int unsigned      IDX_W    = idx_w(KEY_LEN);
  localparam int unsigned      FC_W     = cnt_w(MAX_FAILS);
  localparam int unsigned      CC_W     = cnt_w(KEY_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KEY_LEN - 1);
  localparam logic [FC_W-1:0]  FC_LOCK  = FC_W'(MAX_FAILS);

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_cmp_idx;
  logic [SYM_W-1:0] r_buf [KEY_LEN];
  logic [SYM_W-1:0] r_key [KEY_LEN];
  logic             r_success;
  logic             r_fail;
  logic             r_locked;
  logic [FC_W-1:0]  r_fail_count;
  logic [CC_W-1:0]  r_check_cycles;

  logic             w_sym_mm;
  logic             w_last;
  logic             w_decide;
  logic             w_bad;
  logic [FC_W-1:0]  w_fc_inc;
  logic             w_lock_trip;
  logic             w_lock_start;
  logic             w_timer_expired;

  assign w_sym_mm = (r_buf[r_cmp_idx] != r_key[r_cmp_idx]);
  assign w_last   = (r_cmp_idx == LAST_IDX);

`ifdef KEY_CHECKER_CONSTANT_TIME_EN
  // Sticky mismatch: every symbol is visited, the verdict waits for the last.
  logic r_mm_acc;
  assign w_decide = w_last;
  assign w_bad    = r_mm_acc | w_sym_mm;
`else
  // Early exit on the first mismatch; the data-dependent duration is the
  // side channel this block exists to demonstrate.
  assign w_decide = w_last | w_sym_mm;
  assign w_bad    = w_sym_mm;
`endif

  assign w_fc_inc     = (r_fail_count == '1) ? r_fail_count : r_fail_count + 1'b1;
  assign w_lock_trip  = (MAX_FAILS > 0) && (w_fc_inc == FC_LOCK);
  assign w_lock_start = (r_state == CHECK) && w_decide && w_bad && w_lock_trip;

  lockout_timer #(
    .CYCLES(LOCKOUT_CYCLES)
  ) u_lockout_timer (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_lock_start),
    .o_expired(w_timer_expired)
  );

  assign bus.sym_ready    = (r_state == COLLECT);
  assign bus.success      = r_success;
  assign bus.fail         = r_fail;
  assign bus.locked       = r_locked;
  assign bus.fail_count   = r_fail_count;
  assign bus.check_cycles = r_check_cycles;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= COLLECT;
      r_idx          <= '0;
      r_cmp_idx      <= '0;
      for (int i = 0; i < KEY_LEN; i++) begin
        r_buf[i] <= '0;
        r_key[i] <= '0;
      end
      r_success      <= 1'b0;
      r_fail         <= 1'b0;
      r_locked       <= 1'b0;
      r_fail_count   <= '0;
      r_check_cycles <= '0;
`ifdef KEY_CHECKER_CONSTANT_TIME_EN
      r_mm_acc       <= 1'b0;
`endif
    end else begin
      r_fail <= 1'b0;
      unique case (r_state)
        COLLECT: begin
          // restart outranks a simultaneous symbol, which is dropped.
          if (bus.restart) begin
            r_idx <= '0;
          end else if (bus.sym_valid) begin
            r_buf[r_idx] <= bus.sym_in;
            if (r_idx == LAST_IDX) begin
              // Snapshot the key so later changes cannot alter this attempt.
              for (int i = 0; i < KEY_LEN; i++) r_key[i] <= bus.key[SYM_W*i +: SYM_W];
              r_idx     <= '0;
              r_cmp_idx <= '0;
              r_state   <= CHECK;
`ifdef KEY_CHECKER_CONSTANT_TIME_EN
              r_mm_acc  <= 1'b0;
`endif
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        CHECK: begin
`ifdef KEY_CHECKER_CONSTANT_TIME_EN
          r_mm_acc <= w_bad;
`endif
          if (w_decide) begin
            r_check_cycles <= CC_W'(r_cmp_idx) + CC_W'(1);
            if (w_bad) begin
              r_fail       <= 1'b1;
              r_fail_count <= w_fc_inc;
              r_idx        <= '0;
              if (w_lock_trip) begin
                r_locked <= 1'b1;
                r_state  <= LOCKOUT;
              end else begin
                r_state  <= COLLECT;
              end
            end else begin
              r_success    <= 1'b1;
              r_fail_count <= '0;
              r_state      <= DONE;
            end
          end else begin
            r_cmp_idx <= r_cmp_idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.restart) begin
            r_success <= 1'b0;
            r_idx     <= '0;
            r_state   <= COLLECT;
          end
        end
        LOCKOUT: begin
          if (w_timer_expired) begin
            r_locked     <= 1'b0;
            r_fail_count <= '0;
            r_idx        <= '0;
            r_state      <= COLLECT;
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_key_checker_param.sv
// Purpose: self-checking bench for key_checker_param (directed steps plus randomized attempts).
// Latency: n/a.
// Backpressure: symbols are only offered while sym_ready is expected high.
module tb_key_checker_param;
  localparam int unsigned SYM_W    = 2;
  localparam int unsigned KEY_LEN  = 4;
  localparam int unsigned MAX_F    = 3;
  localparam int unsigned LOCK_CYC = 100;
`ifdef KEY_CHECKER_CONSTANT_TIME_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  key_checker_param_if #(.SYM_W(SYM_W), .KEY_LEN(KEY_LEN), .MAX_FAILS(MAX_F)) bus ();

  key_checker_param #(
    .SYM_W(SYM_W), .KEY_LEN(KEY_LEN), .MAX_FAILS(MAX_F), .LOCKOUT_CYCLES(LOCK_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int m_fc    = 0;  // reference consecutive-failure count

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: index of the first differing symbol, KEY_LEN when all agree.
  function automatic int first_mismatch(input logic [7:0] g, input logic [7:0] k);
    for (int i = 0; i < KEY_LEN; i++)
      if (((int'(g) >> (SYM_W * i)) % 4) != ((int'(k) >> (SYM_W * i)) % 4)) return i;
    return KEY_LEN;
  endfunction

  // One full attempt: enter the guess, time the verdict, check all status,
  // then return to COLLECT (restart, plain fail, full lockout or reset abort).
  task automatic attempt(input string tag, input logic [7:0] g, input logic [7:0] k_after,
                         input bit abort_lock);
    int mm, exp_lat, lat, run;
    bit exp_ok, exp_lock, ready_bad;
    mm       = first_mismatch(g, bus.key);
    exp_ok   = (mm == KEY_LEN);
    exp_lat  = (exp_ok || CT) ? KEY_LEN : mm + 1;
    m_fc     = exp_ok ? 0 : m_fc + 1;
    exp_lock = !exp_ok && (m_fc == MAX_F);

    chk({tag, " ready_pre"}, bus.sym_ready, 1);
    for (int i = 0; i < KEY_LEN; i++) begin
      bus.sym_valid = 1'b1;
      bus.sym_in    = g[SYM_W*i +: SYM_W];
      tick();
    end
    bus.sym_valid = 1'b0;
    bus.key       = k_after;  // now in T0: key changes must not matter

    lat = 0;
    for (int n = 1; n <= KEY_LEN + 3; n++) begin
      tick();
      if (bus.success || bus.fail) begin
        lat = n;
        break;
      end
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " verdict"}, {bus.success, bus.fail}, {exp_ok, !exp_ok});
    chk({tag, " check_cycles"}, bus.check_cycles, exp_lat);
    chk({tag, " fail_count"}, bus.fail_count, m_fc);
    chk({tag, " locked"}, bus.locked, exp_lock);

    if (exp_ok) begin
      chk({tag, " ready_done"}, bus.sym_ready, 0);
      bus.restart = 1'b1;
      tick();
      bus.restart = 1'b0;
      chk({tag, " success_drop"}, bus.success, 0);
      chk({tag, " ready_restart"}, bus.sym_ready, 1);
    end else if (exp_lock && abort_lock) begin
      repeat (10) tick();
      #2 rst = 1'b0;
      #1;
      chk({tag, " async_rst_outs"},
          {bus.success, bus.fail, bus.locked, 1'(bus.fail_count != 0), 1'(bus.check_cycles != 0)}, 0);
      chk({tag, " async_rst_ready"}, bus.sym_ready, 1);
      @(negedge clk) rst = 1'b1;
      tick();
      m_fc = 0;
    end else if (exp_lock) begin
      run = 1;
      ready_bad = bus.sym_ready;
      for (int n = 0; n < LOCK_CYC + 50; n++) begin
        bus.sym_valid = 1'b1;
        bus.sym_in    = SYM_W'($urandom);
        bus.restart   = 1'($urandom);
        tick();
        if (!bus.locked) break;
        run++;
        if (bus.sym_ready) ready_bad = 1'b1;
      end
      bus.sym_valid = 1'b0;
      bus.restart   = 1'b0;
      chk({tag, " lock_len"}, run, LOCK_CYC);
      chk({tag, " lock_ready"}, ready_bad, 0);
      chk({tag, " unlock_fc"}, bus.fail_count, 0);
      chk({tag, " unlock_ready"}, bus.sym_ready, 1);
      m_fc = 0;
    end else begin
      tick();
      chk({tag, " fail_pulse"}, bus.fail, 0);
      chk({tag, " ready_fail"}, bus.sym_ready, 1);
    end
  endtask

  initial begin
    logic [31:0] r;
    logic [7:0]  k, g;
    bus.sym_valid = 1'b0;
    bus.sym_in    = '0;
    bus.restart   = 1'b0;
    bus.key       = 8'hE4;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst outs", {bus.success, bus.fail, bus.locked}, 0);
    chk("rst fail_count", bus.fail_count, 0);
    chk("rst check_cycles", bus.check_cycles, 0);
    @(negedge clk) rst = 1'b1;
    tick();
    chk("rst ready", bus.sym_ready, 1);

    // Correct key, then early-exit failures building up to lockout
    attempt("ok0123", 8'hE4, 8'hE4, 1'b0);
    attempt("g0130", 8'h34, 8'hE4, 1'b0);
    r = $urandom;
    attempt("g3xxx", {r[5:0], 2'b11}, 8'hE4, 1'b0);
    attempt("g0120", 8'h24, 8'hE4, 1'b0);
    attempt("ok_after_lock", 8'hE4, 8'hE4, 1'b0);

    // restart together with a symbol: the partial entry and that symbol vanish
    bus.sym_valid = 1'b1;
    bus.sym_in = 2'd0; tick();
    bus.sym_in = 2'd1; tick();
    bus.sym_in = 2'd2; bus.restart = 1'b1; tick();
    bus.sym_valid = 1'b0; bus.restart = 1'b0;
    attempt("restart_drop", 8'hE4, 8'hE4, 1'b0);

    // Key changed mid-CHECK is ignored
    attempt("snapshot", 8'hE4, 8'h00, 1'b0);
    bus.key = 8'hE4;

    // Third failure locks; reset mid-lockout aborts everything
    attempt("pre_abort1", 8'h00, 8'hE4, 1'b0);
    attempt("pre_abort2", 8'h34, 8'hE4, 1'b0);
    attempt("abort", 8'h24, 8'hE4, 1'b1);
    attempt("ok_after_rst", 8'hE4, 8'hE4, 1'b0);

    // Randomized attempts against the reference model
    for (int t = 0; t < 30; t++) begin
      k = 8'($urandom);
      bus.key = k;
      g = ($urandom_range(0, 2) == 0) ? k : 8'($urandom);
      attempt("rnd", g, k, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, failed so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/key_checker_param.md
Name: key_checker_param

Overview:
- Parametrised successor to the 4-press key checker.
- Collects KEY_LEN symbols of SYM_W bits from an upstream debounced-symbol source via a valid/ready handshake, then compares them serially against a key vector, one symbol per cycle.
- The default comparison exits early on the first mismatch; this data-dependent timing is intentional for the timing-attack demonstration.
- Adds a failure counter with timed lockout and exposes the measured compare length so the attack can be observed.

Parameters:
- SYM_W, 2: bits per symbol (button code).
- KEY_LEN, 4: symbols per key.
- MAX_FAILS, 3: consecutive failures that trigger lockout; 0 disables lockout.
- LOCKOUT_CYCLES, 1000: lockout duration in clk cycles; must be ≥1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low.
- sym_valid  in  1  upstream symbol valid.
- sym_in  in  SYM_W  symbol value.
- sym_ready  out  1  block accepts a symbol this cycle.
- key  in  KEY_LEN*SYM_W  correct key; symbol i is key[SYM_W*i +: SYM_W].
- restart  in  1  level request to start a new attempt.
- success  out  1  level, high while in DONE.
- fail  out  1  one-cycle pulse per failed attempt.
- locked  out  1  high while in LOCKOUT.
- fail_count  out  clog2(MAX_FAILS+1)  consecutive failures.
- check_cycles  out  clog2(KEY_LEN+1)  compare cycles used by the last attempt.

Behaviour:
- Reset (rst low, async):
  - state = COLLECT, symbol index 0, buffer cleared.
  - success = 0, fail = 0, locked = 0, fail_count = 0, check_cycles = 0.
  - sym_ready = 1 after reset deasserts.
- States: COLLECT, CHECK, DONE, LOCKOUT.
- COLLECT:
  - sym_ready = 1.
  - When sym_valid && sym_ready, store sym_in at the index position (first symbol is index 0) and increment the index.
  - When the KEY_LEN-th symbol is accepted, go to CHECK on the next edge and snapshot key into an internal register at the same edge. Later key changes do not affect the attempt.
  - restart in COLLECT clears the index and discards the partial entry. restart wins over a simultaneous sym_valid; that symbol is dropped.
- CHECK (entered at cycle T0):
  - sym_ready = 0.
  - Symbol i is compared in cycle T0+i.
  - On the first mismatch at index i: fail pulses in cycle T0+i+1, check_cycles = i+1, fail_count increments (saturating), and the next state is COLLECT with index cleared. If the new fail_count equals MAX_FAILS (and MAX_FAILS > 0), the next state is LOCKOUT instead.
  - If all symbols match: success rises at T0+KEY_LEN, check_cycles = KEY_LEN, fail_count = 0, state = DONE.
  - restart is ignored during CHECK.
- DONE:
  - success held high, sym_ready = 0.
  - restart → COLLECT on the next edge; success drops in that same cycle; index cleared.
- LOCKOUT:
  - locked is asserted in the same cycle as the triggering fail pulse.
  - sym_ready = 0; restart and sym_valid are ignored.
  - After exactly LOCKOUT_CYCLES cycles: locked = 0, fail_count = 0, state = COLLECT.
- Boundaries:
  - fail and success are never both high.
  - KEY_LEN = 1 is legal: a single compare cycle.
  - Reset during any state aborts immediately to reset values, including mid-lockout.

Optional Feature:
- Macro: KEY_CHECKER_CONSTANT_TIME_EN.
- Defined:
  - CHECK always runs all KEY_LEN compare cycles and accumulates a sticky mismatch flag.
  - success or fail is issued at T0+KEY_LEN.
  - check_cycles is always KEY_LEN.
  - Counter and lockout behaviour are unchanged.
- Undefined: early-exit behaviour as above (leaky by design).

Decomposition:
- Package key_checker_pkg:
  - state enum (COLLECT, CHECK, DONE, LOCKOUT).
  - width helper constants for the index, fail_count and check_cycles widths, via clog2.
- Sub-module lockout_timer: load/count-down counter of LOCKOUT_CYCLES with a start input and an expired pulse output.
- Symbol buffer and compare stay in the top module.

Test Plan (SYM_W=2, KEY_LEN=4, MAX_FAILS=3, LOCKOUT_CYCLES=100, key=8'hE4, i.e. symbols 0,1,2,3):
- Send 0,1,2,3 → success rises 4 cycles after CHECK entry, check_cycles=4, fail_count=0; restart → success=0, sym_ready=1.
- Send 0,1,3,0 → fail pulse 3 cycles after CHECK entry, check_cycles=3, fail_count=1, back in COLLECT; send 3,x,x,x → check_cycles=1.
- Three wrong attempts → third fail pulse coincides with locked=1; sym_valid ignored for 100 cycles; then locked=0, fail_count=0, and a correct key then succeeds.
- Send 0,1 then restart together with sym_valid(2) → index reset, symbol 2 dropped; then 0,1,2,3 → success.
- Change key mid-CHECK to 8'h00 with guess 0,1,2,3 → still success (snapshot); assert rst low mid-LOCKOUT → all outputs return to reset values asynchronously.
- With KEY_CHECKER_CONSTANT_TIME_EN: guesses 3,x,x,x and 0,1,2,0 → both fail at T0+4, check_cycles=4.
